receptor_serial: RTL
====================

RECEPTOR_SERIAL -- requirements
Module: receptor_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the frame length in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port inicio  input  1  one-cycle frame-start strobe from the serial transmitter (its load phase).
REQ-005 The block SHALL have port bit_in  input  1  serial data bit, LSB first.
REQ-006 The block SHALL have port bit_en  input  1  bit_in is valid this cycle (transmitter shift phase).
REQ-007 The block SHALL have port ack  input  1  consumer accepts dado this cycle.
REQ-008 The block SHALL have port dado  output  WIDTH  last completely received word.
REQ-009 The block SHALL have port dado_valido  output  1  dado holds an unaccepted word.
REQ-010 The block SHALL have port ocupado  output  1  frame reception in progress.
REQ-011 The block SHALL have port aborto  output  1  one-cycle pulse: a partial frame was discarded.
REQ-012 The block SHALL have port overrun  output  1  sticky: an unaccepted word was overwritten; cleared only by rst.

Function
REQ-013 The FSM SHALL have two states: ESPERA (idle) and RECEBE (shifting); ocupado = 1 exactly when in RECEBE (registered state, no combinational path from inputs).
REQ-014 ESPERA: inicio=1 -> RECEBE with bit counter cleared to 0; bit_en ignored; in the same cycle as inicio, bit_in is not sampled.
REQ-015 RECEBE, bit_en=1, inicio=0: shift register <= {bit_in, shreg[WIDTH-1:1]}; counter +1.
REQ-016 RECEBE, bit_en=0, inicio=0: hold shift register, counter and state; no timeout exists.
REQ-017 On the edge sampling bit number WIDTH-1 (the WIDTH-th bit): dado <= {bit_in, shreg[WIDTH-1:1]}, dado_valido <= 1, counter <= 0, state -> ESPERA; dado visible one cycle after the last bit edge.
REQ-018 RECEBE, inicio=1 (with or without bit_en): discard partial frame, counter <= 0, stay RECEBE, aborto = 1 for the following cycle only; bit_in not sampled that cycle.
REQ-019 ack=1 with dado_valido=1 and no completion that cycle: dado_valido <= 0; dado keeps its value.
REQ-020 ack=1 with dado_valido=0: ignored.
REQ-021 Completion while dado_valido=1 and ack=0: dado overwritten, dado_valido stays 1, overrun <= 1.
REQ-022 Completion and ack in the same cycle: old word consumed, new word loaded, dado_valido stays 1, overrun unchanged.
REQ-023 Reception of a new frame SHALL proceed while dado_valido=1 (dado and shift register are separate registers).
REQ-024 Counter width SHALL be ceil(log2(WIDTH)) bits and never exceed WIDTH-1.

Reset
REQ-025 rst=1 at a clock edge SHALL force: state ESPERA, counter 0, shift register 0, dado 0, dado_valido 0, ocupado 0, aborto 0, overrun 0.
REQ-026 rst SHALL take priority over every other input, including mid-frame and during completion; the partial frame is lost and no aborto pulse is produced.

Verification
REQ-027 WIDTH=8: inicio, then bit_en on 8 consecutive cycles with bits 1,0,1,1,0,0,1,0 -> dado=8'h4D, dado_valido=1 one cycle after 8th bit, ocupado 0 same cycle.
REQ-028 Same frame with bit_en gaps of 0-3 idle cycles between bits -> identical dado=8'h4D; ocupado held 1 throughout gaps.
REQ-029 inicio after 5 bits, then full frame 8'hA5 -> aborto pulse exactly one cycle after the second inicio; dado=8'hA5; no word from the partial frame.
REQ-030 Frame 8'h3C unacked, then frame 8'hC3 completes with ack=0 -> dado=8'hC3, overrun=1, stays 1 after later ack; repeat with ack on completion cycle -> overrun stays 0.
REQ-031 rst asserted after 4 bits of a frame -> all outputs 0 next cycle; subsequent bit_en without inicio ignored; next full frame 8'hFF received correctly.

Source files
------------

// File: rtl/receptor_serial.sv
// Serial frame receiver: collects WIDTH bits (LSB first) between an inicio strobe and
// the last bit_en, then presents the word on dado with a valid/ack handshake.
module receptor_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             ack,
    output logic [WIDTH-1:0] dado,
    output logic             dado_valido,
    output logic             ocupado,
    output logic             aborto,
    output logic             overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        ESPERA = 1'b0,
        RECEBE = 1'b1
    } estadoType;

    estadoType        estado;
    logic [CW-1:0]    bitCnt;
    logic [WIDTH-1:0] shiftReg;
    logic [WIDTH-1:0] nextWord;
    logic             lastBit;

    assign nextWord = {bit_in, shiftReg[WIDTH-1:1]};
    assign lastBit  = (bitCnt == LAST_BIT);
    assign ocupado  = (estado == RECEBE);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= ESPERA;
            bitCnt      <= '0;
            shiftReg    <= '0;
            dado        <= '0;
            dado_valido <= 1'b0;
            aborto      <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            aborto <= 1'b0;
            // Consumption; a completion later in this block re-asserts dado_valido.
            if (ack && dado_valido)
                dado_valido <= 1'b0;

            case (estado)
                ESPERA: begin
                    if (inicio) begin
                        estado <= RECEBE;
                        bitCnt <= '0;
                    end
                end
                RECEBE: begin
                    if (inicio) begin
                        bitCnt <= '0;
                        aborto <= 1'b1;
                    end else if (bit_en) begin
                        shiftReg <= nextWord;
                        if (lastBit) begin
                            dado        <= nextWord;
                            dado_valido <= 1'b1;
                            bitCnt      <= '0;
                            estado      <= ESPERA;
                            if (dado_valido && !ack)
                                overrun <= 1'b1;
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule
